// File: rtl/decode_pkg.sv
// Shared types and RV32I encodings for the decode stage and its immediate generator.
package decode_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, ILLEGAL
  } op_class_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    op_class_e       op;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [4:0]      rd;
    logic            rd_we;
  } idex_t;

  localparam idex_t IDEX_RESET = '{
    pc: '0, rs1_val: '0, rs2_val: '0, imm: '0, op: ILLEGAL,
    funct3: '0, funct7b5: 1'b0, rd: '0, rd_we: 1'b0
  };

  function automatic logic writes_rd(input op_class_e op);
    case (op)
      ALU_R, ALU_I, LOAD, JAL, JALR, LUI, AUIPC: writes_rd = 1'b1;
      default:                                   writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; format is chosen by the decoder.
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:7]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field decode, 32-entry scoreboard and the ID/EX register.
// Define DECODE_WB_BYPASS_EN to let an issuing source take the same-cycle writeback value.
module decode_stage
  import decode_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [3:0]      ex_op,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_we
);

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  op_class_e       op;
  imm_fmt_e        fmt;
  logic            use_rs1, use_rs2, rd_we;
  logic [XLEN-1:0] imm;
  logic            byp1, byp2, hazard, accept;
  logic [XLEN-1:0] rs1_val, rs2_val;

  idex_t           ex_q, ex_d;
  logic            ex_valid_q, ex_valid_d;
  logic [31:0]     busy_q, busy_d;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign rf_a1  = rs1;
  assign rf_a2  = rs2;

  always_comb begin
    op      = ILLEGAL;
    fmt     = IMM_NONE;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OPC_OP:     begin op = ALU_R;  use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_OP_IMM: begin op = ALU_I;  fmt = IMM_I; use_rs1 = 1'b1; end
      OPC_LOAD:   begin op = LOAD;   fmt = IMM_I; use_rs1 = 1'b1; end
      OPC_STORE:  begin op = STORE;  fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_BRANCH: begin op = BRANCH; fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_JAL:    begin op = JAL;    fmt = IMM_J; end
      OPC_JALR:   begin op = JALR;   fmt = IMM_I; use_rs1 = 1'b1; end
      OPC_LUI:    begin op = LUI;    fmt = IMM_U; end
      OPC_AUIPC:  begin op = AUIPC;  fmt = IMM_U; end
      default:    op = ILLEGAL;
    endcase
  end

  assign rd_we = writes_rd(op) && (rd != 5'd0);

  imm_gen u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (fmt),
    .imm   (imm)
  );

`ifdef DECODE_WB_BYPASS_EN
  assign byp1 = wb_valid && (wb_rd == rs1) && (rs1 != 5'd0);
  assign byp2 = wb_valid && (wb_rd == rs2) && (rs2 != 5'd0);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign rs1_val = byp1 ? wb_data : rf_rd1;
  assign rs2_val = byp2 ? wb_data : rf_rd2;

  // A pending rd also blocks issue so that a younger write never overtakes an older one.
  assign hazard = (use_rs1 && busy_q[rs1] && !byp1) ||
                  (use_rs2 && busy_q[rs2] && !byp2) ||
                  (rd_we && busy_q[rd]);

  assign in_ready = (!ex_valid_q || ex_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d     = 1'b1;
      ex_d.pc        = in_pc;
      ex_d.rs1_val   = rs1_val;
      ex_d.rs2_val   = rs2_val;
      ex_d.imm       = imm;
      ex_d.op        = op;
      ex_d.funct3    = in_instr[14:12];
      ex_d.funct7b5  = in_instr[30];
      ex_d.rd        = rd;
      ex_d.rd_we     = rd_we;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  // Later assignments take priority: a set from accept overrides any clear.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid && (wb_rd != 5'd0)) busy_d[wb_rd] = 1'b0;
    if (flush && ex_valid_q && ex_q.rd_we) busy_d[ex_q.rd] = 1'b0;
    if (accept && rd_we) busy_d[rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= IDEX_RESET;
      busy_q     <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
      busy_q     <= busy_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_q.pc;
  assign ex_rs1_val  = ex_q.rs1_val;
  assign ex_rs2_val  = ex_q.rs2_val;
  assign ex_imm      = ex_q.imm;
  assign ex_op       = ex_q.op;
  assign ex_funct3   = ex_q.funct3;
  assign ex_funct7b5 = ex_q.funct7b5;
  assign ex_rd       = ex_q.rd;
  assign ex_rd_we    = ex_q.rd_we;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios then randomized traffic vs a rule-level model.
// Honours DECODE_WB_BYPASS_EN the same way the design does.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [3:0]  ex_op;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_op(ex_op), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we)
  );

  // Register file stand-in: combinational reads, write on the clock edge.
  logic [31:0] regs [32];
  assign rf_rd1 = (rf_a1 == 5'd0) ? 32'd0 : regs[rf_a1];
  assign rf_rd2 = (rf_a2 == 5'd0) ? 32'd0 : regs[rf_a2];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h1000 + 32'(i);
    end else if (wb_valid && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  int checks = 0;
  int failures = 0;

  bit          m_valid;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
  logic [3:0]  m_op;
  logic [2:0]  m_f3;
  logic        m_f7;
  logic [4:0]  m_rd;
  logic        m_we;
  logic [31:0] m_busy;
  logic        last_acc;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    return v[bits-1] ? (v | (32'hFFFF_FFFF << bits)) : v;
  endfunction

  // Reference decode from the RV32I encoding tables.
  function automatic void ref_decode(input logic [31:0] i, output logic [3:0] op,
                                     output logic [31:0] imm, output logic we,
                                     output logic u1, output logic u2);
    logic [31:0] raw;
    op = ILLEGAL; imm = 32'd0; we = 1'b0; u1 = 1'b0; u2 = 1'b0;
    case (i[6:0])
      7'h33: begin op = ALU_R; u1 = 1; u2 = 1; we = 1; end
      7'h13: begin op = ALU_I; imm = sext(32'(i[31:20]), 12); u1 = 1; we = 1; end
      7'h03: begin op = LOAD;  imm = sext(32'(i[31:20]), 12); u1 = 1; we = 1; end
      7'h23: begin
        op = STORE; u1 = 1; u2 = 1;
        imm = sext(32'(i[31:25]) * 32 + 32'(i[11:7]), 12);
      end
      7'h63: begin
        op = BRANCH; u1 = 1; u2 = 1;
        raw = 32'(i[31]) * 4096 + 32'(i[7]) * 2048 + 32'(i[30:25]) * 32 + 32'(i[11:8]) * 2;
        imm = sext(raw, 13);
      end
      7'h6F: begin
        op = JAL; we = 1;
        raw = 32'(i[31]) * 1048576 + 32'(i[19:12]) * 4096 + 32'(i[20]) * 2048 + 32'(i[30:21]) * 2;
        imm = sext(raw, 21);
      end
      7'h67: begin op = JALR;  imm = sext(32'(i[31:20]), 12); u1 = 1; we = 1; end
      7'h37: begin op = LUI;   imm = i & 32'hFFFF_F000; we = 1; end
      7'h17: begin op = AUIPC; imm = i & 32'hFFFF_F000; we = 1; end
      default: ;
    endcase
    if (i[11:7] == 5'd0) we = 1'b0;
  endfunction

  task automatic check_ex();
    check_output("ex_valid", 32'(ex_valid), 32'(m_valid));
    if (m_valid) begin
      check_output("ex_pc", ex_pc, m_pc);
      check_output("ex_rs1_val", ex_rs1_val, m_rs1);
      check_output("ex_rs2_val", ex_rs2_val, m_rs2);
      check_output("ex_imm", ex_imm, m_imm);
      check_output("ex_op", 32'(ex_op), 32'(m_op));
      check_output("ex_funct3", 32'(ex_funct3), 32'(m_f3));
      check_output("ex_funct7b5", 32'(ex_funct7b5), 32'(m_f7));
      check_output("ex_rd", 32'(ex_rd), 32'(m_rd));
      check_output("ex_rd_we", 32'(ex_rd_we), 32'(m_we));
    end
    check_output("busy", dut.busy_q, m_busy);
  endtask

  // One clock cycle: drive at the falling edge, check, then step the model across the rising edge.
  task automatic apply_stimulus(input bit v, input logic [31:0] instr, input bit er, input bit fl,
                                input bit wbv, input logic [4:0] wbrd, input logic [31:0] wbd);
    logic [3:0]  op;
    logic [31:0] imm, v1, v2, pc, nb;
    logic        we, u1, u2, h1, h2, haz, exp_rdy, acc;
    logic [4:0]  rs1, rs2, rd;
    pc = $urandom & 32'hFFFF_FFFC;
    in_valid = v; in_instr = instr; in_pc = pc; ex_ready = er; flush = fl;
    wb_valid = wbv; wb_rd = wbrd; wb_data = wbd;
    #1;
    ref_decode(instr, op, imm, we, u1, u2);
    rs1 = instr[19:15]; rs2 = instr[24:20]; rd = instr[11:7];
`ifdef DECODE_WB_BYPASS_EN
    h1 = wbv && wbrd == rs1 && rs1 != 0;
    h2 = wbv && wbrd == rs2 && rs2 != 0;
`else
    h1 = 1'b0;
    h2 = 1'b0;
`endif
    v1 = h1 ? wbd : ((rs1 == 0) ? 32'd0 : regs[rs1]);
    v2 = h2 ? wbd : ((rs2 == 0) ? 32'd0 : regs[rs2]);
    haz = (u1 && m_busy[rs1] && !h1) || (u2 && m_busy[rs2] && !h2) || (we && m_busy[rd]);
    exp_rdy = (!m_valid || er) && !haz && !fl;
    check_output("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_output("rf_a1", 32'(rf_a1), 32'(rs1));
    check_output("rf_a2", 32'(rf_a2), 32'(rs2));
    acc = v && exp_rdy;
    last_acc = acc;
    nb = m_busy;
    if (wbv && wbrd != 0) nb[wbrd] = 1'b0;
    if (fl && m_valid && m_we) nb[m_rd] = 1'b0;
    if (acc && we) nb[rd] = 1'b1;
    m_busy = nb;
    if (fl) m_valid = 0;
    else if (acc) begin
      m_valid = 1; m_pc = pc; m_rs1 = v1; m_rs2 = v2; m_imm = imm; m_op = op;
      m_f3 = instr[14:12]; m_f7 = instr[30]; m_rd = rd; m_we = we;
    end else if (er) m_valid = 0;
    @(posedge clk);
    #1;
    check_ex();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; ex_ready = 1'b0;
    flush = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_ex_valid", 32'(ex_valid), 32'd0);
    check_output("rst_ex_pc", ex_pc, 32'd0);
    check_output("rst_ex_rs1", ex_rs1_val, 32'd0);
    check_output("rst_ex_rs2", ex_rs2_val, 32'd0);
    check_output("rst_ex_imm", ex_imm, 32'd0);
    check_output("rst_ex_op", 32'(ex_op), 32'(ILLEGAL));
    check_output("rst_ex_rd", 32'(ex_rd), 32'd0);
    check_output("rst_ex_rd_we", 32'(ex_rd_we), 32'd0);
    check_output("rst_busy", dut.busy_q, 32'd0);
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    m_valid = 0; m_busy = 32'd0;
  endtask

  function automatic logic [6:0] pick_opcode(input int k);
    case (k)
      0: return 7'h33;  1: return 7'h13;  2: return 7'h03;  3: return 7'h23;
      4: return 7'h63;  5: return 7'h6F;  6: return 7'h67;  7: return 7'h37;
      8: return 7'h17;  9: return 7'h0F; 10: return 7'h73;
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] held_pc, instr;
    bit v, er, fl, wbv;
    logic [4:0] wbrd;
    int cand[$];

    do_reset();

    // addi x1,x0,5
    apply_stimulus(1, 32'h0050_0093, 1, 0, 0, 5'd0, 32'd0);
    check_output("addi_op", 32'(ex_op), 32'(ALU_I));
    check_output("addi_imm", ex_imm, 32'd5);
    check_output("addi_rd", 32'(ex_rd), 32'd1);
    check_output("addi_busy1", 32'(dut.busy_q[1]), 32'd1);

    // add x2,x1,x1 stalls on x1 until it retires
    apply_stimulus(1, 32'h0010_8133, 1, 0, 0, 5'd0, 32'd0);
    check_output("add_stall", 32'(last_acc), 32'd0);
    apply_stimulus(1, 32'h0010_8133, 1, 0, 1, 5'd1, 32'd5);
`ifdef DECODE_WB_BYPASS_EN
    check_output("add_bypass_acc", 32'(last_acc), 32'd1);
`else
    check_output("add_wb_cycle_stall", 32'(last_acc), 32'd0);
    apply_stimulus(1, 32'h0010_8133, 1, 0, 0, 5'd0, 32'd0);
    check_output("add_late_acc", 32'(last_acc), 32'd1);
`endif
    check_output("add_rs1_val", ex_rs1_val, 32'd5);
    check_output("add_rs2_val", ex_rs2_val, 32'd5);

    // backpressure for three cycles, then a single consume
    held_pc = ex_pc;
    repeat (3) begin
      apply_stimulus(1, 32'h0010_0193, 0, 0, 0, 5'd0, 32'd0);
      check_output("bp_hold_pc", ex_pc, held_pc);
      check_output("bp_no_accept", 32'(last_acc), 32'd0);
    end
    apply_stimulus(1, 32'h0010_0193, 1, 0, 0, 5'd0, 32'd0);
    check_output("bp_release_acc", 32'(last_acc), 32'd1);

    // flush the addi x3 entry
    apply_stimulus(1, 32'h0050_0093, 1, 1, 0, 5'd0, 32'd0);
    check_output("flush_no_accept", 32'(last_acc), 32'd0);
    check_output("flush_valid", 32'(ex_valid), 32'd0);
    check_output("flush_busy3", 32'(dut.busy_q[3]), 32'd0);

    apply_stimulus(0, 32'd0, 1, 0, 1, 5'd2, 32'h0000_0022);

    // illegal word
    apply_stimulus(1, 32'hFFFF_FFFF, 1, 0, 0, 5'd0, 32'd0);
    check_output("illegal_op", 32'(ex_op), 32'(ILLEGAL));
    check_output("illegal_we", 32'(ex_rd_we), 32'd0);
    check_output("illegal_busy", dut.busy_q, 32'd0);

    // addi x0,x0,7 and a writeback to x0
    apply_stimulus(1, 32'h0070_0013, 1, 0, 0, 5'd0, 32'd0);
    check_output("x0_we", 32'(ex_rd_we), 32'd0);
    apply_stimulus(0, 32'd0, 1, 0, 1, 5'd0, 32'h1234_5678);
    check_output("wb_x0_busy", dut.busy_q, 32'd0);

    // reset in the middle of a stall
    apply_stimulus(1, 32'h0050_0293, 1, 0, 0, 5'd0, 32'd0);
    apply_stimulus(1, 32'h0052_8333, 1, 0, 0, 5'd0, 32'd0);
    check_output("pre_rst_stall", 32'(last_acc), 32'd0);
    do_reset();
    apply_stimulus(1, 32'h0052_8333, 1, 0, 0, 5'd0, 32'd0);
    check_output("post_rst_acc", 32'(last_acc), 32'd1);

    // randomized traffic; writeback only retires registers already past ID/EX
    for (int n = 0; n < 600; n++) begin
      instr = $urandom;
      instr[6:0]   = pick_opcode($urandom_range(0, 11));
      instr[11:7]  = 5'($urandom_range(0, 7));
      instr[19:15] = 5'($urandom_range(0, 7));
      instr[24:20] = 5'($urandom_range(0, 7));
      v  = ($urandom_range(0, 3) != 0);
      er = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 15) == 0);
      cand.delete();
      for (int r = 1; r < 32; r++)
        if (m_busy[r] && !(m_valid && m_we && m_rd == 5'(r))) cand.push_back(r);
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        wbv = 1; wbrd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      end else begin
        wbv = ($urandom_range(0, 7) == 0); wbrd = 5'd0;
      end
      apply_stimulus(v, instr, er, fl, wbv, wbrd, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the single-issue RISC-V core. Accepts fetched instructions over a valid/ready handshake, decodes the RV32I fields and immediates, drives the register file read addresses, and captures source operands into an ID/EX pipeline register. Contains a 32-entry scoreboard that stalls issue on pending destination writes until writeback retires them. Sits between fetch and execute; writeback drives the register file write port directly, and mirrors that write here.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch holds a valid instruction
- in_ready  out  1  decode accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- rf_a1, rf_a2  out  5  register file read addresses, combinational from in_instr[19:15] and in_instr[24:20]
- rf_rd1, rf_rd2  in  XLEN  register file read data, combinational, x0 reads 0
- wb_valid  in  1  writeback commits this cycle
- wb_rd  in  5  writeback destination; 0 ignored
- wb_data  in  XLEN  writeback value
- flush  in  1  discard the ID/EX entry
- ex_valid  out  1  ID/EX entry valid
- ex_ready  in  1  execute consumes the entry
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  XLEN  captured PC, operands, sign-extended immediate
- ex_op  out  4  op class: ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, ILLEGAL
- ex_funct3  out  3; ex_funct7b5  out  1  instr[14:12], instr[30]
- ex_rd  out  5; ex_rd_we  out  1  destination and its write enable

## Operation
- Decode: opcode [6:0] selects ex_op. FENCE, SYSTEM and unknown opcodes map to ILLEGAL. Immediate formats I/S/B/U/J follow the RV32I encodings; the immediate is 0 for R-type.
- rd_we is 1 for ALU_R, ALU_I, LOAD, JAL, JALR, LUI and AUIPC, but only when rd != 0. ILLEGAL is forced to rd_we=0.
- Hazard: stall when a used source register (rs1 and/or rs2 per op class) or the rd of an rd_we instruction has busy=1. A busy bit clears in the cycle wb_valid && wb_rd matches it.
- in_ready = (!ex_valid || ex_ready) && !hazard && !flush.
- Accept: in_valid && in_ready. The ID/EX register loads all fields, including rf_rd1/rf_rd2 (or the bypass value). If rd_we, busy[rd] is set.
- Consume without accept: ex_valid drops to 0.
- Flush: ex_valid cleared next cycle. If the flushed entry had rd_we, its busy bit is cleared. No accept happens that cycle.
- Simultaneous events on one busy bit: a set from accept wins over a clear from writeback. A clear from flush or writeback wins over a held set.

## Timing
- Latency 1 cycle from accept to ex_valid.
- Full throughput when there are no hazards and ex_ready=1.
- Under backpressure (ex_valid && !ex_ready) all ex_* outputs hold stable.
- Stall release: without the bypass, issue resumes the cycle after the clearing writeback, because the register file updates on that edge.
- Reset: ex_valid=0, all ex_* outputs=0, ex_op=ILLEGAL, busy=0. in_ready follows its equation.
- Asserting rst mid-stall discards the ID/EX entry and the whole scoreboard.

## Configuration
- DECODE_WB_BYPASS_EN defined:
  - A source matching wb_rd while wb_valid is not treated as a hazard.
  - Its operand captures wb_data instead of rf_rdN.
  - Issue proceeds in the same cycle as the writeback.
- Undefined: that source stalls one extra cycle and reads the register file.

## Structure
- decode_pkg holds:
  - op_class_e (4-bit enum)
  - RV32I opcode localparams
  - the imm_fmt_e enum
- imm_gen is a purely combinational sub-module that takes the instruction and format and produces the XLEN immediate.
- Scoreboard and ID/EX register live in decode_stage.

## Test plan
- After reset, addi x1,x0,5 (0x00500093): next cycle ex_valid=1, ex_op=ALU_I, ex_imm=5, ex_rd=1, ex_rd_we=1, busy[1]=1.
- add x2,x1,x1 (0x00108133) with x1 busy:
  - in_ready=0 until wb_valid, wb_rd=1, wb_data=5.
  - With the macro: accepted that cycle, ex_rs1_val=ex_rs2_val=5.
  - Without the macro: accepted one cycle later.
- ex_ready=0 for 3 cycles with entry held: ex_* stable, in_ready=0, then a single consume is observed.
- flush while ID/EX holds addi x3,x0,1: ex_valid=0 next cycle, busy[3]=0, no accept that cycle.
- 0xFFFFFFFF: ex_op=ILLEGAL, ex_rd_we=0, no busy bit set.
- addi x0,x0,7: ex_rd_we=0, busy unchanged. wb_valid with wb_rd=0 leaves busy unchanged.
